gate_vector_checker: RTL and testbench
======================================

Name: gate_vector_checker

Overview:
- Self-checking stimulus and response stage wrapped around the two-input basic-gate block.
- Drives all four (a,b) combinations onto the gate block and samples its seven outputs.
- Compares each sample against a built-in golden truth table and counts failing vectors.
- Lets the gate block be exercised on silicon or in a synthesizable bench, without a behavioural testbench.

Parameters:
- SETTLE_CYCLES, 2, cycles between driving a vector and sampling outputs (0 allowed).
- NUM_PASSES, 1, number of full 4-vector sweeps per run (>=1).
- ERR_W, 8, width of the mismatch counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that starts a run; honoured only when busy=0.
- a  output  1  stimulus to the gate block.
- b  output  1  stimulus to the gate block.
- gate_obs  input  7  observed gate outputs: [0]and [1]nand [2]or [3]nor [4]xor [5]xnor [6]not.
- busy  output  1  high while a run is in progress.
- done  output  1  sticky run-complete flag.
- pass  output  1  valid when done=1; 1 if err_count==0.
- err_count  output  ERR_W  number of failing vectors, saturating.
- first_fail_vec  output  2  {a,b} of the first failing vector of the run.
- first_fail_mask  output  7  XOR of observed and expected outputs at the first failure.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; a=0, b=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_mask=0; vector index, pass index and settle counter all 0. Reset takes effect immediately, including mid-run; no partial results are kept.
- States are IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE: on start=1, clear err_count, first_fail_*, done, pass and all indices; go to DRIVE; busy=1 from the next cycle.
- DRIVE (1 cycle): register a=vec[1], b=vec[0] for the current 2-bit vector index vec. Go to SETTLE, or to CHECK if SETTLE_CYCLES=0.
- SETTLE: hold a/b for exactly SETTLE_CYCLES cycles, then go to CHECK.
- CHECK (1 cycle): sample gate_obs and compare against the expected word, computed from the registered a/b:
  - and = a&b
  - nand = ~(a&b)
  - or = a|b
  - nor = ~(a|b)
  - xor = a^b
  - xnor = ~(a^b)
  - not = ~a
- Any mismatching bit makes the vector fail:
  - err_count increments by 1 per failing vector (not per bit) and saturates at 2^ERR_W-1.
  - On the first failure of a run only, capture first_fail_vec={a,b} and first_fail_mask=obs^expected.
- After CHECK:
  - If vec<3: vec increments and the FSM returns to DRIVE.
  - If vec==3 and pass index < NUM_PASSES-1: vec wraps to 0, pass index increments, FSM returns to DRIVE.
  - Otherwise the FSM goes to DONE.
- Vector order is 00, 01, 10, 11.
- Timing: each vector takes 2+SETTLE_CYCLES cycles. done rises exactly 1 + 4*NUM_PASSES*(2+SETTLE_CYCLES) cycles after the start cycle.
- DONE: busy=0, done=1, pass=(err_count==0). a/b hold the last vector. Outputs stay stable until the next start, which clears them and re-enters DRIVE directly.
- start while busy=1 is ignored, with no effect on indices or counts.
- gate_obs is sampled only in CHECK; its value in every other state is don't-care.

Test Plan:
- Ideal gate model, defaults, start pulse -> a/b step through 00,01,10,11; done=1 and busy=0 exactly 17 cycles after start; pass=1, err_count=0, first_fail_mask=0.
- xor bit stuck at 0 -> failures at vectors 01 and 10; err_count=2, pass=0, first_fail_vec=01, first_fail_mask=7'b0010000.
- ERR_W=2, NUM_PASSES=2, all gate_obs bits inverted -> 8 failing vectors; err_count saturates at 3; first_fail_vec=00, first_fail_mask=7'h7F.
- start re-pulsed on cycles 3 and 9 of a run -> ignored; timing and results identical to the first scenario.
- rst_n low mid-SETTLE of vector 10 -> all outputs 0 immediately; after release, a fresh start completes normally with err_count=0.
- SETTLE_CYCLES=0, ideal model -> 2 cycles per vector; done 9 cycles after start; pass=1.

Source files
------------

// File: rtl/gate_vector_checker.sv
// Stimulus/response checker for the two-input basic-gate block: sweeps all four
// (a,b) vectors, compares the seven gate outputs with a golden table and counts failures.
module gate_vector_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic [6:0]       gate_obs,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       first_fail_vec,
    output logic [6:0]       first_fail_mask
);

    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(NUM_PASSES - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX     = {ERR_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Golden word, bit order [0]and [1]nand [2]or [3]nor [4]xor [5]xnor [6]not.
    function automatic logic [6:0] expected_word(input logic va, input logic vb);
        expected_word = {~va, ~(va ^ vb), va ^ vb, ~(va | vb), va | vb, ~(va & vb), va & vb};
    endfunction

    state_t              state_r, state_s;
    logic [1:0]          vec_r, vec_s;
    logic [PASS_W-1:0]   pass_idx_r, pass_idx_s;
    logic [SET_W-1:0]    settle_r, settle_s;
    logic                a_r, a_s, b_r, b_s;
    logic                busy_r, busy_s, done_r, done_s, pass_r, pass_s;
    logic [ERR_W-1:0]    err_r, err_s;
    logic [1:0]          ffv_r, ffv_s;
    logic [6:0]          ffm_r, ffm_s;
    logic [6:0]          mask_s;
    logic                start_ok_s;

    assign start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   state_s = start ? ST_DRIVE : ST_IDLE;
            ST_DRIVE:  state_s = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
            ST_SETTLE: state_s = (settle_r == SETTLE_LAST) ? ST_CHECK : ST_SETTLE;
            ST_CHECK: begin
                if ((vec_r != 2'd3) || (pass_idx_r != PASS_LAST)) begin
                    state_s = ST_DRIVE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_DONE:   state_s = start ? ST_DRIVE : ST_DONE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Output/datapath next values; status flags follow the next state so they
    // line up with the state the FSM is entering.
    always_comb begin
        vec_s      = vec_r;
        pass_idx_s = pass_idx_r;
        settle_s   = settle_r;
        a_s        = a_r;
        b_s        = b_r;
        err_s      = err_r;
        ffv_s      = ffv_r;
        ffm_s      = ffm_r;
        mask_s     = gate_obs ^ expected_word(a_r, b_r);
        if (start_ok_s) begin
            vec_s      = 2'd0;
            pass_idx_s = '0;
            settle_s   = '0;
            err_s      = '0;
            ffv_s      = 2'd0;
            ffm_s      = 7'd0;
        end else begin
            case (state_r)
                ST_DRIVE: begin
                    a_s      = vec_r[1];
                    b_s      = vec_r[0];
                    settle_s = '0;
                end
                ST_SETTLE: settle_s = settle_r + 1'b1;
                ST_CHECK: begin
                    if (mask_s != 7'd0) begin
                        // err_count still zero means this is the run's first failure
                        if (err_r == '0) begin
                            ffv_s = {a_r, b_r};
                            ffm_s = mask_s;
                        end else begin
                            ffv_s = ffv_r;
                            ffm_s = ffm_r;
                        end
                        if (err_r != ERR_MAX) begin
                            err_s = err_r + 1'b1;
                        end else begin
                            err_s = err_r;
                        end
                    end else begin
                        err_s = err_r;
                    end
                    if (vec_r != 2'd3) begin
                        vec_s = vec_r + 2'd1;
                    end else if (pass_idx_r != PASS_LAST) begin
                        vec_s      = 2'd0;
                        pass_idx_s = pass_idx_r + 1'b1;
                    end else begin
                        vec_s = vec_r;
                    end
                end
                default: vec_s = vec_r;
            endcase
        end
        busy_s = (state_s == ST_DRIVE) || (state_s == ST_SETTLE) || (state_s == ST_CHECK);
        done_s = (state_s == ST_DONE);
        pass_s = done_s && (err_s == '0);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_r      <= 2'd0;
            pass_idx_r <= '0;
            settle_r   <= '0;
            a_r        <= 1'b0;
            b_r        <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            err_r      <= '0;
            ffv_r      <= 2'd0;
            ffm_r      <= 7'd0;
        end else begin
            vec_r      <= vec_s;
            pass_idx_r <= pass_idx_s;
            settle_r   <= settle_s;
            a_r        <= a_s;
            b_r        <= b_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            pass_r     <= pass_s;
            err_r      <= err_s;
            ffv_r      <= ffv_s;
            ffm_r      <= ffm_s;
        end
    end

    assign a               = a_r;
    assign b               = b_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign pass            = pass_r;
    assign err_count       = err_r;
    assign first_fail_vec  = ffv_r;
    assign first_fail_mask = ffm_r;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: three instances (default, saturating 2-pass, zero-settle)
// driven by a gate model with injectable faults; run results go through a scoreboard queue.
module tb_gate_vector_checker;

    typedef struct {
        int         cycles;
        logic [7:0] err;
        logic       ps;
        logic [1:0] fv;
        logic [6:0] fm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start0, start1, start2;
    logic [1:0] mode0, mode1, mode2;
    logic a0, b0, a1, b1, a2, b2;
    logic [6:0] obs0, obs1, obs2;
    logic busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
    logic [7:0] err0, err2;
    logic [1:0] err1;
    logic [1:0] ffv0, ffv1, ffv2;
    logic [6:0] ffm0, ffm1, ffm2;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Truth table as constants indexed by {a,b}: [0]and [1]nand [2]or [3]nor [4]xor [5]xnor [6]not
    function automatic logic [6:0] gate_model(input logic va, input logic vb, input logic [1:0] m);
        logic [6:0] t;
        case ({va, vb})
            2'b00:   t = 7'b1101010;
            2'b01:   t = 7'b1010110;
            2'b10:   t = 7'b0010110;
            default: t = 7'b0100101;
        endcase
        case (m)
            2'd1:    gate_model = t & 7'b1101111;
            2'd2:    gate_model = ~t;
            default: gate_model = t;
        endcase
    endfunction

    assign obs0 = gate_model(a0, b0, mode0);
    assign obs1 = gate_model(a1, b1, mode1);
    assign obs2 = gate_model(a2, b2, mode2);

    gate_vector_checker u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .gate_obs(obs0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ffv0), .first_fail_mask(ffm0));

    gate_vector_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(2), .ERR_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .gate_obs(obs1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_vec(ffv1), .first_fail_mask(ffm1));

    gate_vector_checker #(.SETTLE_CYCLES(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .gate_obs(obs2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_fail_vec(ffv2), .first_fail_mask(ffm2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int sel, output logic [1:0] ab, output logic bz, output logic dn,
                          output logic ps, output logic [7:0] ec, output logic [1:0] fv,
                          output logic [6:0] fm);
        case (sel)
            0: begin ab = {a0, b0}; bz = busy0; dn = done0; ps = pass0; ec = err0; fv = ffv0; fm = ffm0; end
            1: begin ab = {a1, b1}; bz = busy1; dn = done1; ps = pass1; ec = {6'd0, err1}; fv = ffv1; fm = ffm1; end
            default: begin ab = {a2, b2}; bz = busy2; dn = done2; ps = pass2; ec = err2; fv = ffv2; fm = ffm2; end
        endcase
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       start0 = v;
            1:       start1 = v;
            default: start2 = v;
        endcase
    endtask

    task automatic check_all_zero(input int sel, input string tag);
        logic [1:0] ab, fv; logic bz, dn, ps; logic [7:0] ec; logic [6:0] fm;
        sample(sel, ab, bz, dn, ps, ec, fv, fm);
        check({tag, "_ab"}, 32'(ab), 32'd0);
        check({tag, "_status"}, {29'd0, bz, dn, ps}, 32'd0);
        check({tag, "_err"}, 32'(ec), 32'd0);
        check({tag, "_first_fail"}, {23'd0, fv, fm}, 32'd0);
    endtask

    // One run: pulse start, follow it cycle by cycle, then pop and compare the expectation.
    task automatic do_run(input int sel, input int np, input int per, input bit repulse,
                          input int rst_at, input logic [7:0] e_err, input logic e_ps,
                          input logic [1:0] e_fv, input logic [6:0] e_fm);
        logic [1:0] ab, fv; logic bz, dn, ps; logic [7:0] ec; logic [6:0] fm;
        exp_t e;
        int   n;
        bit   fin;
        if (rst_at < 0) begin
            e.cycles = 1 + 4 * np * per; e.err = e_err; e.ps = e_ps; e.fv = e_fv; e.fm = e_fm;
            sb.push_back(e);
        end
        @(negedge clk); set_start(sel, 1'b1);
        @(posedge clk); n = 0;
        @(negedge clk); set_start(sel, 1'b0);
        fin = 1'b0;
        while (!fin && n < 300) begin
            sample(sel, ab, bz, dn, ps, ec, fv, fm);
            if (n >= 1 && ((n - 1) % per) == 0 && ((n - 1) / per) < 4 * np && !dn)
                check("vector_order", 32'(ab), 32'(((n - 1) / per) % 4));
            if (n == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero(sel, "mid_run_reset");
                @(negedge clk); rst_n = 1'b1;
                fin = 1'b1;
            end else if (dn) begin
                fin = 1'b1;
            end else begin
                check("busy_during_run", 32'(bz), 32'd1);
                if (repulse && (n == 2 || n == 8)) set_start(sel, 1'b1);
                @(posedge clk); n++;
                @(negedge clk); set_start(sel, 1'b0);
            end
        end
        if (rst_at < 0) begin
            e = sb.pop_front();
            check("done_seen", 32'(dn), 32'd1);
            check("done_latency", n + 1, e.cycles);
            check("busy_at_done", 32'(bz), 32'd0);
            check("pass", 32'(ps), 32'(e.ps));
            check("err_count", 32'(ec), 32'(e.err));
            check("first_fail_vec", 32'(fv), 32'(e.fv));
            check("first_fail_mask", 32'(fm), 32'(e.fm));
            check("ab_hold_last", 32'(ab), 32'd3);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        mode0  = 2'd0; mode1  = 2'd0; mode2  = 2'd0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) check_all_zero(s, "reset");
        rst_n = 1'b1;
        @(negedge clk);

        do_run(0, 1, 4, 1'b0, -1, 8'd0, 1'b1, 2'b00, 7'd0);
        mode0 = 2'd1;
        do_run(0, 1, 4, 1'b0, -1, 8'd2, 1'b0, 2'b01, 7'b0010000);
        mode0 = 2'd0;
        do_run(0, 1, 4, 1'b1, -1, 8'd0, 1'b1, 2'b00, 7'd0);
        do_run(0, 1, 4, 1'b0, 9, 8'd0, 1'b0, 2'b00, 7'd0);
        do_run(0, 1, 4, 1'b0, -1, 8'd0, 1'b1, 2'b00, 7'd0);
        mode1 = 2'd2;
        do_run(1, 2, 4, 1'b0, -1, 8'd3, 1'b0, 2'b00, 7'h7F);
        do_run(2, 1, 2, 1'b0, -1, 8'd0, 1'b1, 2'b00, 7'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
